// File: rtl/unit_pkg.sv
// rtl/unit_pkg.sv - unit type codes, slot state encoding, type tables and pool defaults
package unit_pkg;

    typedef enum logic [1:0] {
        UT_NONE   = 2'd0,
        UT_LIGHT  = 2'd1,
        UT_MEDIUM = 2'd2,
        UT_HEAVY  = 2'd3
    } unit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEPLOY = 2'd1,
        ST_ALIVE  = 2'd2
    } slot_state_e;

    localparam int N_SLOTS_DEF   = 4;
    localparam int POS_W_DEF     = 9;
    localparam int HP_W_DEF      = 8;
    localparam int DMG_W_DEF     = 8;
    localparam int SPAWN_POS_DEF = 511;
    localparam int SPAWN_GAP_DEF = 8;
    localparam int ATK_CD_DEF    = 3;

    function automatic logic [7:0] unit_hp(input logic [1:0] t);
        case (t)
            UT_LIGHT, UT_MEDIUM, UT_HEAVY: unit_hp = 8'd255;
            default:                       unit_hp = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] unit_power(input logic [1:0] t);
        case (t)
            UT_LIGHT:  unit_power = 8'd32;
            UT_MEDIUM: unit_power = 8'd64;
            UT_HEAVY:  unit_power = 8'd255;
            default:   unit_power = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/unit_slot.sv
// rtl/unit_slot.sv - one unit slot: lifecycle FSM with hp, position and attack cooldown
module unit_slot
    import unit_pkg::*;
#(
    parameter int POS_W     = POS_W_DEF,
    parameter int HP_W      = HP_W_DEF,
    parameter int DMG_W     = DMG_W_DEF,
    parameter int SPAWN_POS = SPAWN_POS_DEF,
    parameter int ATK_CD    = ATK_CD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              deploy_i,
    input  logic [1:0]        type_i,
    input  logic              move_tick_i,
    input  logic [POS_W-1:0]  enemy_front_i,
    input  logic              hit_i,
    input  logic [DMG_W-1:0]  damage_i,
    output slot_state_e       state_o,
    output logic [1:0]        type_o,
    output logic [POS_W-1:0]  pos_o,
    output logic [DMG_W-1:0]  power_o,
    output logic              fire_o
);

    localparam int CD_W = (ATK_CD > 1) ? $clog2(ATK_CD + 1) : 1;
    localparam int CW   = (HP_W > DMG_W) ? HP_W : DMG_W;

    slot_state_e      state_q;
    logic [1:0]       type_q;
    logic [HP_W-1:0]  hp_q;
    logic [HP_W-1:0]  hp_d;
    logic [POS_W-1:0] pos_q;
    logic [CD_W-1:0]  cd_q;
    logic [DMG_W-1:0] power_q;
    logic             advance;
    logic             killed;

    assign advance = enemy_front_i < pos_q;
    assign killed  = (state_q == ST_ALIVE) && hit_i && (CW'(hp_q) <= CW'(damage_i));
    // Survivors only: damage is strictly below hp here, so it fits in HP_W.
    assign hp_d    = hit_i ? hp_q - HP_W'(damage_i) : hp_q;
    assign fire_o  = (state_q == ST_ALIVE) && move_tick_i && !advance && (cd_q == '0) && !killed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            type_q  <= 2'd0;
            hp_q    <= '0;
            pos_q   <= '1;
            cd_q    <= '0;
            power_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (deploy_i) begin
                        state_q <= ST_DEPLOY;
                        type_q  <= type_i;
                        hp_q    <= HP_W'(unit_hp(type_i));
                        power_q <= DMG_W'(unit_power(type_i));
                        pos_q   <= POS_W'(SPAWN_POS);
                        cd_q    <= '0;
                    end
                end
                ST_DEPLOY: state_q <= ST_ALIVE;
                ST_ALIVE: begin
                    if (killed) begin
                        state_q <= ST_IDLE;
                        type_q  <= 2'd0;
                        hp_q    <= '0;
                        pos_q   <= '1;
                        cd_q    <= '0;
                        power_q <= '0;
                    end else begin
                        hp_q <= hp_d;
                        if (move_tick_i) begin
                            if (advance)
                                pos_q <= pos_q - 1'b1;
                            else if (cd_q == '0)
                                cd_q <= CD_W'(ATK_CD - 1);
                            else
                                cd_q <= cd_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign type_o  = type_q;
    assign pos_o   = pos_q;
    assign power_o = power_q;

endmodule

// File: rtl/unit_pool.sv
// rtl/unit_pool.sv - pool of unit slots with spawn arbitration, front tracking and damage aggregation
module unit_pool
    import unit_pkg::*;
#(
    parameter int N_SLOTS   = N_SLOTS_DEF,
    parameter int POS_W     = POS_W_DEF,
    parameter int HP_W      = HP_W_DEF,
    parameter int DMG_W     = DMG_W_DEF,
    parameter int SPAWN_POS = SPAWN_POS_DEF,
    parameter int SPAWN_GAP = SPAWN_GAP_DEF,
    parameter int ATK_CD    = ATK_CD_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spawn_req_i,
    input  logic [1:0]               spawn_type_i,
    output logic                     spawn_ack_o,
    input  logic                     move_tick_i,
    input  logic                     damage_en_i,
    input  logic [DMG_W-1:0]         damage_in_i,
    input  logic [POS_W-1:0]         enemy_front_i,
    output logic [POS_W-1:0]         front_pos_o,
    output logic                     front_valid_o,
    output logic [DMG_W-1:0]         damage_out_o,
    output logic                     damage_valid_o,
    output logic [N_SLOTS-1:0]       alive_mask_o,
    output logic [2*N_SLOTS-1:0]     slot_type_o,
    output logic [POS_W*N_SLOTS-1:0] slot_pos_o
);

    localparam int IDX_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int SUM_W     = DMG_W + $clog2(N_SLOTS + 1);
    localparam int GAP_LIMIT = SPAWN_POS - SPAWN_GAP;

    slot_state_e                   state_w [N_SLOTS];
    logic [N_SLOTS-1:0][POS_W-1:0] pos_w;
    logic [N_SLOTS-1:0][DMG_W-1:0] power_w;
    logic [N_SLOTS-1:0]            fire_w;
    logic [N_SLOTS-1:0]            hit_w;
    logic [N_SLOTS-1:0]            deploy_sel;
    logic [N_SLOTS-1:0]            deploy_w;
    logic [N_SLOTS-1:0]            alive_mask;
    logic                          any_idle;
    logic                          gap_ok;
    logic                          accept;
    logic                          found;
    logic [POS_W-1:0]              best_pos;
    logic [IDX_W-1:0]              best_idx;
    logic [SUM_W-1:0]              sum;
    logic [DMG_W-1:0]              damage_d;

    logic                          spawn_ack_q;
    logic [DMG_W-1:0]              damage_q;
    logic                          damage_valid_q;
    logic [POS_W-1:0]              front_pos_q;
    logic                          front_valid_q;

    // Deploying units already sit at SPAWN_POS, so they count toward the gap rule.
    always_comb begin
        any_idle   = 1'b0;
        deploy_sel = '0;
        gap_ok     = 1'b1;
        alive_mask = '0;
        found      = 1'b0;
        best_pos   = '1;
        best_idx   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (state_w[i] == ST_IDLE && !any_idle) begin
                deploy_sel[i] = 1'b1;
                any_idle      = 1'b1;
            end
            if (state_w[i] != ST_IDLE && int'(pos_w[i]) > GAP_LIMIT)
                gap_ok = 1'b0;
            alive_mask[i] = (state_w[i] == ST_ALIVE);
            if (alive_mask[i] && (!found || pos_w[i] < best_pos)) begin
                found    = 1'b1;
                best_pos = pos_w[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    assign accept   = spawn_req_i && (spawn_type_i != 2'd0) && any_idle && gap_ok;
    assign deploy_w = accept ? deploy_sel : '0;

    always_comb begin
        hit_w = '0;
        if (damage_en_i && found)
            hit_w[best_idx] = 1'b1;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_SLOTS; i++)
            if (fire_w[i])
                sum = sum + SUM_W'(power_w[i]);
    end

    assign damage_d = (|sum[SUM_W-1:DMG_W]) ? '1 : sum[DMG_W-1:0];

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        unit_slot #(
            .POS_W    (POS_W),
            .HP_W     (HP_W),
            .DMG_W    (DMG_W),
            .SPAWN_POS(SPAWN_POS),
            .ATK_CD   (ATK_CD)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .deploy_i     (deploy_w[g]),
            .type_i       (spawn_type_i),
            .move_tick_i  (move_tick_i),
            .enemy_front_i(enemy_front_i),
            .hit_i        (hit_w[g]),
            .damage_i     (damage_in_i),
            .state_o      (state_w[g]),
            .type_o       (slot_type_o[2*g +: 2]),
            .pos_o        (pos_w[g]),
            .power_o      (power_w[g]),
            .fire_o       (fire_w[g])
        );
        assign slot_pos_o[POS_W*g +: POS_W] = pos_w[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spawn_ack_q    <= 1'b0;
            damage_q       <= '0;
            damage_valid_q <= 1'b0;
            front_pos_q    <= '1;
            front_valid_q  <= 1'b0;
        end else begin
            spawn_ack_q    <= accept;
            damage_q       <= move_tick_i ? damage_d : '0;
            damage_valid_q <= move_tick_i;
            front_pos_q    <= found ? best_pos : '1;
            front_valid_q  <= found;
        end
    end

    assign spawn_ack_o    = spawn_ack_q;
    assign damage_out_o   = damage_q;
    assign damage_valid_o = damage_valid_q;
    assign front_pos_o    = front_pos_q;
    assign front_valid_o  = front_valid_q;
    assign alive_mask_o   = alive_mask;

endmodule

// File: tb/tb_unit_pool.sv
// tb/tb_unit_pool.sv - randomized and directed checks of unit_pool against a game-rule model
module tb_unit_pool;

    localparam int N   = 4;
    localparam int PW  = 9;
    localparam int SP  = 511;
    localparam int GAP = 8;
    localparam int CD  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spawn_req = 1'b0;
    logic [1:0]    spawn_type = 2'd0;
    logic          move_tick = 1'b0;
    logic          damage_en = 1'b0;
    logic [7:0]    damage_in = 8'd0;
    logic [PW-1:0] enemy_front = '0;
    logic          spawn_ack;
    logic [PW-1:0] front_pos;
    logic          front_valid;
    logic [7:0]    damage_out;
    logic          damage_valid;
    logic [N-1:0]  alive_mask;
    logic [2*N-1:0]  slot_type;
    logic [PW*N-1:0] slot_pos;

    int checks = 0;
    int errors = 0;

    // Game-level model: unit records plus the registered outputs expected after the edge.
    int m_st [N];
    int m_ty [N];
    int m_hp [N];
    int m_pos[N];
    int m_cd [N];
    int e_ack, e_dv, e_dout, e_fpos, e_fval;

    unit_pool dut (
        .clk           (clk),
        .reset         (reset),
        .spawn_req_i   (spawn_req),
        .spawn_type_i  (spawn_type),
        .spawn_ack_o   (spawn_ack),
        .move_tick_i   (move_tick),
        .damage_en_i   (damage_en),
        .damage_in_i   (damage_in),
        .enemy_front_i (enemy_front),
        .front_pos_o   (front_pos),
        .front_valid_o (front_valid),
        .damage_out_o  (damage_out),
        .damage_valid_o(damage_valid),
        .alive_mask_o  (alive_mask),
        .slot_type_o   (slot_type),
        .slot_pos_o    (slot_pos)
    );

    always #5 clk = ~clk;

    function automatic int power_of(input int t);
        case (t)
            1: return 32;
            2: return 64;
            3: return 255;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_ty[i] = 0; m_hp[i] = 0; m_pos[i] = SP; m_cd[i] = 0;
        end
        e_ack = 0; e_dv = 0; e_dout = 0; e_fpos = SP; e_fval = 0;
    endtask

    task automatic model_step();
        int fidx;
        int free;
        int sum;
        bit blocked;
        bit accept;
        bit hit;
        fidx = -1; free = -1; sum = 0; blocked = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 2 && (fidx < 0 || m_pos[i] < m_pos[fidx])) fidx = i;
            if (m_st[i] == 0 && free < 0) free = i;
            if (m_st[i] != 0 && m_pos[i] > SP - GAP) blocked = 1;
        end
        accept = spawn_req && spawn_type != 0 && free >= 0 && !blocked;
        e_fval = (fidx >= 0);
        e_fpos = (fidx >= 0) ? m_pos[fidx] : SP;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 0) begin
                if (accept && i == free) begin
                    m_st[i] = 1; m_ty[i] = int'(spawn_type); m_hp[i] = 255; m_pos[i] = SP; m_cd[i] = 0;
                end
            end else if (m_st[i] == 1) begin
                m_st[i] = 2;
            end else begin
                hit = damage_en && i == fidx;
                if (hit && m_hp[i] <= int'(damage_in)) begin
                    m_st[i] = 0; m_ty[i] = 0; m_hp[i] = 0; m_pos[i] = SP; m_cd[i] = 0;
                end else begin
                    if (hit) m_hp[i] -= int'(damage_in);
                    if (move_tick) begin
                        if (int'(enemy_front) < m_pos[i]) m_pos[i] -= 1;
                        else if (m_cd[i] == 0) begin sum += power_of(m_ty[i]); m_cd[i] = CD - 1; end
                        else m_cd[i] -= 1;
                    end
                end
            end
        end
        e_ack  = accept;
        e_dv   = move_tick;
        e_dout = move_tick ? ((sum > 255) ? 255 : sum) : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; spawn_req = 0; spawn_type = 0; move_tick = 0; damage_en = 0; damage_in = 0;
        enemy_front = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic spawn_and_wait(input logic [1:0] t, input int move_cycles);
        spawn_req = 1; spawn_type = t; tick(); spawn_req = 0;
        move_tick = (move_cycles > 0);
        repeat ((move_cycles > 0) ? move_cycles : 1) tick();
        move_tick = 0;
    endtask

    task automatic setup_pair(input logic [1:0] t0, input logic [1:0] t1);
        do_reset();
        enemy_front = '0;
        spawn_and_wait(t0, 10);
        spawn_and_wait(t1, 0);
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1; #1;
        checks++; if (alive_mask !== '0) begin errors++; $display("FAIL rst_alive got %h want 0", alive_mask); end
        checks++; if (slot_type !== '0) begin errors++; $display("FAIL rst_type got %h want 0", slot_type); end
        checks++; if (slot_pos !== '1) begin errors++; $display("FAIL rst_pos got %h want all-ones", slot_pos); end
        checks++; if (front_pos !== 9'h1ff || front_valid !== 1'b0) begin errors++; $display("FAIL rst_front got %h/%b want 1ff/0", front_pos, front_valid); end
        checks++; if (damage_out !== 8'd0 || damage_valid !== 1'b0 || spawn_ack !== 1'b0) begin errors++; $display("FAIL rst_pulses got %0d/%b/%b want 0/0/0", damage_out, damage_valid, spawn_ack); end
        reset = 1'b0;
    endtask

    task automatic test_spawn_single();
        do_reset();
        spawn_req = 1; spawn_type = 2'd1; tick(); spawn_req = 0;
        checks++; if (spawn_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b want 1", spawn_ack); end
        checks++; if (alive_mask !== 4'b0000) begin errors++; $display("FAIL single_deploy_mask got %b want 0000", alive_mask); end
        tick();
        checks++; if (alive_mask !== 4'b0001) begin errors++; $display("FAIL single_alive got %b want 0001", alive_mask); end
        checks++; if (slot_pos[8:0] !== 9'd511 || slot_type[1:0] !== 2'd1) begin errors++; $display("FAIL single_slot0 got pos %0d type %0d want 511 1", slot_pos[8:0], slot_type[1:0]); end
        checks++; if (spawn_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got %b want 0", spawn_ack); end
        tick();
        checks++; if (front_pos !== 9'd511 || front_valid !== 1'b1) begin errors++; $display("FAIL single_front got %0d/%b want 511/1", front_pos, front_valid); end
    endtask

    task automatic test_gap();
        do_reset();
        enemy_front = '0;
        spawn_and_wait(2'd2, 8);
        spawn_req = 1; spawn_type = 2'd1; move_tick = 1; tick(); move_tick = 0;
        checks++; if (spawn_ack !== 1'b0) begin errors++; $display("FAIL gap_504_ack got %b want 0", spawn_ack); end
        checks++; if (slot_pos[8:0] !== 9'd503) begin errors++; $display("FAIL gap_pos got %0d want 503", slot_pos[8:0]); end
        tick(); spawn_req = 0;
        checks++; if (spawn_ack !== 1'b1) begin errors++; $display("FAIL gap_503_ack got %b want 1", spawn_ack); end
    endtask

    task automatic test_fill();
        int acks;
        acks = 0;
        do_reset();
        enemy_front = '0;
        for (int k = 0; k < 4; k++) begin
            spawn_req = 1; spawn_type = 2'($urandom_range(1, 3)); tick(); spawn_req = 0;
            acks += int'(spawn_ack);
            move_tick = 1; repeat (10) tick(); move_tick = 0;
        end
        spawn_req = 1; spawn_type = 2'd1; tick(); spawn_req = 0;
        checks++; if (spawn_ack !== 1'b0) begin errors++; $display("FAIL fill_5th_ack got %b want 0", spawn_ack); end
        checks++; if (acks != 4) begin errors++; $display("FAIL fill_acks got %0d want 4", acks); end
        checks++; if (alive_mask !== 4'b1111) begin errors++; $display("FAIL fill_mask got %b want 1111", alive_mask); end
    endtask

    task automatic test_attack();
        int want;
        do_reset();
        spawn_and_wait(2'd3, 0);
        enemy_front = 9'd509;
        for (int t = 1; t <= 6; t++) begin
            move_tick = 1; tick(); move_tick = 0;
            want = (t == 3 || t == 6) ? 255 : 0;
            checks++; if (damage_valid !== 1'b1 || int'(damage_out) != want) begin errors++; $display("FAIL attack_tick%0d got %0d/%b want %0d/1", t, damage_out, damage_valid, want); end
            tick();
            checks++; if (damage_valid !== 1'b0 || damage_out !== 8'd0) begin errors++; $display("FAIL attack_idle%0d got %0d/%b want 0/0", t, damage_out, damage_valid); end
        end
        checks++; if (slot_pos[8:0] !== 9'd509) begin errors++; $display("FAIL attack_pos got %0d want 509", slot_pos[8:0]); end
    endtask

    task automatic test_pair_fire(input logic [1:0] t0, input logic [1:0] t1, input int want);
        setup_pair(t0, t1);
        enemy_front = 9'd511;
        move_tick = 1; tick(); move_tick = 0;
        checks++; if (damage_valid !== 1'b1 || int'(damage_out) != want) begin errors++; $display("FAIL pair_%0d_%0d got %0d/%b want %0d/1", t0, t1, damage_out, damage_valid, want); end
        tick();
        checks++; if (damage_valid !== 1'b0) begin errors++; $display("FAIL pair_pulse got %b want 0", damage_valid); end
    endtask

    task automatic test_damage();
        setup_pair(2'd1, 2'd2);
        damage_en = 1; damage_in = 8'd200; tick(); damage_en = 0;
        checks++; if (alive_mask !== 4'b0011) begin errors++; $display("FAIL dmg200_mask got %b want 0011", alive_mask); end
        checks++; if (front_pos !== 9'd502) begin errors++; $display("FAIL dmg200_front got %0d want 502", front_pos); end
        damage_en = 1; damage_in = 8'd55; tick(); damage_en = 0;
        checks++; if (alive_mask !== 4'b0010) begin errors++; $display("FAIL dmg55_mask got %b want 0010", alive_mask); end
        checks++; if (slot_type[1:0] !== 2'd0 || slot_pos[8:0] !== 9'h1ff) begin errors++; $display("FAIL dmg55_slot0 got %0d/%0d want 0/511", slot_type[1:0], slot_pos[8:0]); end
        tick();
        checks++; if (front_pos !== 9'd511 || front_valid !== 1'b1) begin errors++; $display("FAIL dmg_newfront got %0d/%b want 511/1", front_pos, front_valid); end
    endtask

    task automatic test_reset_mid();
        setup_pair(2'd3, 2'd3);
        enemy_front = 9'd511;
        move_tick = 1; damage_en = 1; damage_in = 8'd10;
        #2 reset = 1'b1; #1;
        checks++; if (alive_mask !== '0 || slot_type !== '0 || slot_pos !== '1) begin errors++; $display("FAIL midrst_slots got %b/%h/%h want 0/0/all-ones", alive_mask, slot_type, slot_pos); end
        @(posedge clk); #1;
        checks++; if (damage_valid !== 1'b0 || damage_out !== 8'd0 || front_valid !== 1'b0 || front_pos !== 9'h1ff) begin errors++; $display("FAIL midrst_outs got %b/%0d/%b/%0d want 0/0/0/511", damage_valid, damage_out, front_valid, front_pos); end
        move_tick = 0; damage_en = 0; model_reset();
        reset = 1'b0;
        tick();
        checks++; if (damage_valid !== 1'b0 || spawn_ack !== 1'b0) begin errors++; $display("FAIL midrst_after got %b/%b want 0/0", damage_valid, spawn_ack); end
    endtask

    task automatic test_random();
        logic [N-1:0]    ea;
        logic [2*N-1:0]  et;
        logic [PW*N-1:0] ep;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            spawn_req   = ($urandom_range(0, 99) < 35);
            spawn_type  = 2'($urandom_range(0, 3));
            move_tick   = ($urandom_range(0, 99) < 40);
            damage_en   = ($urandom_range(0, 99) < 15);
            damage_in   = 8'($urandom_range(0, 140));
            if ($urandom_range(0, 49) == 0) enemy_front = 9'($urandom_range(0, 511));
            tick();
            for (int i = 0; i < N; i++) begin
                ea[i] = (m_st[i] == 2);
                et[2*i +: 2] = 2'(m_ty[i]);
                ep[PW*i +: PW] = PW'(m_pos[i]);
            end
            checks++; if (alive_mask !== ea) begin errors++; $display("FAIL rnd_mask c%0d got %b want %b", c, alive_mask, ea); end
            checks++; if (slot_type !== et) begin errors++; $display("FAIL rnd_type c%0d got %h want %h", c, slot_type, et); end
            checks++; if (slot_pos !== ep) begin errors++; $display("FAIL rnd_pos c%0d got %h want %h", c, slot_pos, ep); end
            checks++; if (int'(front_pos) != e_fpos || int'(front_valid) != e_fval) begin errors++; $display("FAIL rnd_front c%0d got %0d/%b want %0d/%0d", c, front_pos, front_valid, e_fpos, e_fval); end
            checks++; if (int'(spawn_ack) != e_ack) begin errors++; $display("FAIL rnd_ack c%0d got %b want %0d", c, spawn_ack, e_ack); end
            checks++; if (int'(damage_valid) != e_dv || int'(damage_out) != e_dout) begin errors++; $display("FAIL rnd_dmg c%0d got %0d/%b want %0d/%0d", c, damage_out, damage_valid, e_dout, e_dv); end
        end
        spawn_req = 0; move_tick = 0; damage_en = 0;
    endtask

    initial begin
        test_reset();
        test_spawn_single();
        test_gap();
        test_fill();
        test_attack();
        test_pair_fire(2'd3, 2'd3, 255);
        test_pair_fire(2'd1, 2'd2, 96);
        test_pair_fire(2'd3, 2'd1, 255);
        test_damage();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
